// File: rtl/bs_gnrtr_n_rbtr.sv
// Bus generator and round-robin arbiter.
// Each of `bits` buses arbitrates among `drvrs` devices. The bus pops one packet from a
// pending device and then pushes it to the device addressed by the packet's top byte.
// The top byte may also be the broadcast ID, which addresses every device except the sender.
// Each bus runs a three-state FSM (idle, push, wait), so it carries at most one packet
// every three cycles.
// Ports:
//   clk    - single clock, rising edge
//   reset  - synchronous, active-high
//   pndng  - [bus][dev] device has a queued packet
//   D_pop  - [bus][dev] head packet of each device queue
//   pop    - [bus][dev] one-cycle pulse removing the queue head
//   push   - [bus][dev] one-cycle pulse delivering D_push to the device
//   D_push - [bus][dev] bus data register, identical for every device on a bus
module bs_gnrtr_n_rbtr #(
  parameter int unsigned bits      = 1,
  parameter int unsigned drvrs     = 4,
  parameter int unsigned pckg_sz   = 16,
  parameter logic [7:0]  broadcast = 8'hFF
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [bits-1:0][drvrs-1:0]              pndng,
  input  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_pop,
  output logic [bits-1:0][drvrs-1:0]              pop,
  output logic [bits-1:0][drvrs-1:0]              push,
  output logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_push
);

  localparam int unsigned IdxW = (drvrs > 1) ? $clog2(drvrs) : 1;
  localparam logic [drvrs-1:0] One = drvrs'(1);

  typedef enum logic [1:0] {StIdle, StPush, StWait} state_e;

  for (genvar b = 0; b < bits; b++) begin : g_bus
    state_e             state_q;
    logic [IdxW-1:0]    last_q;
    logic [IdxW-1:0]    src_q;
    logic [pckg_sz-1:0] data_q;
    logic [drvrs-1:0]   pop_q;
    logic [drvrs-1:0]   push_q;

    logic               found;
    logic [IdxW-1:0]    sel;
    logic [IdxW-1:0]    cand;
    logic [7:0]         dest;
    logic [drvrs-1:0]   push_mask;

    // Round-robin: first pending device at or after last_q + 1, wrapping modulo drvrs.
    always_comb begin
      found = 1'b0;
      sel   = '0;
      cand  = '0;
      for (int unsigned i = 0; i < drvrs; i++) begin
        cand = IdxW'((32'(last_q) + 1 + i) % drvrs);
        if (!found && pndng[b][cand]) begin
          found = 1'b1;
          sel   = cand;
        end
      end
    end

    // Destination decode. Broadcast takes precedence. A packet addressed to its own sender
    // or to an ID beyond the device range is dropped.
    always_comb begin
      dest      = data_q[pckg_sz-1 -: 8];
      push_mask = '0;
      if (dest == broadcast) begin
        push_mask        = '1;
        push_mask[src_q] = 1'b0;
      end else if (32'(dest) < drvrs && dest != 8'(src_q)) begin
        push_mask[dest[IdxW-1:0]] = 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        state_q <= StIdle;
        last_q  <= IdxW'(drvrs - 1);
        src_q   <= '0;
        data_q  <= '0;
        pop_q   <= '0;
        push_q  <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            push_q <= '0;
            if (found) begin
              pop_q   <= One << sel;
              data_q  <= D_pop[b][sel];
              src_q   <= sel;
              last_q  <= sel;
              state_q <= StPush;
            end else begin
              pop_q <= '0;
            end
          end
          StPush: begin
            pop_q   <= '0;
            push_q  <= push_mask;
            state_q <= StWait;
          end
          StWait: begin
            // Gives the popped device one cycle to update its pndng bit.
            pop_q   <= '0;
            push_q  <= '0;
            state_q <= StIdle;
          end
          default: begin
            pop_q   <= '0;
            push_q  <= '0;
            state_q <= StIdle;
          end
        endcase
      end
    end

    assign pop[b]    = pop_q;
    assign push[b]   = push_q;
    assign D_push[b] = {drvrs{data_q}};
  end

endmodule

// File: tb/tb_bs_gnrtr_n_rbtr.sv
// Self-checking bench for bs_gnrtr_n_rbtr with two buses, four devices and 16-bit packets.
// Directed vectors run on bus 0 while bus 1 must stay silent. A randomized phase follows.
// In that phase per-device packet queues drive both buses, and the checks use a grant
// schedule model.
module tb_bs_gnrtr_n_rbtr;
  localparam int NB = 2;
  localparam int ND = 4;
  localparam int PW = 16;

  logic clk = 1'b0;
  logic reset;
  logic [NB-1:0][ND-1:0]         pndng;
  logic [NB-1:0][ND-1:0][PW-1:0] D_pop;
  logic [NB-1:0][ND-1:0]         pop;
  logic [NB-1:0][ND-1:0]         push;
  logic [NB-1:0][ND-1:0][PW-1:0] D_push;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bs_gnrtr_n_rbtr #(
    .bits     (NB),
    .drvrs    (ND),
    .pckg_sz  (PW),
    .broadcast(8'hFF)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .pndng (pndng),
    .D_pop (D_pop),
    .pop   (pop),
    .push  (push),
    .D_push(D_push)
  );

  typedef struct packed {
    logic        rst;
    logic [3:0]  pn;
    logic [63:0] dp;
    logic [3:0]  epop;
    logic [3:0]  epush;
    logic [15:0] edata;
  } vec_t;

  vec_t tbl[$];

  // Per-device packet queues for the randomized phase.
  logic [15:0] q [NB][ND][$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic [3:0] pn, input logic [63:0] dp,
                              input logic [3:0] ep, input logic [3:0] eu,
                              input logic [15:0] ed);
    vec_t v;
    v.rst = r; v.pn = pn; v.dp = dp; v.epop = ep; v.epush = eu; v.edata = ed;
    return v;
  endfunction

  // Drive one row on bus 0, clock once, then check bus 0 against the row.
  // Bus 1 must stay quiet.
  task automatic apply(input vec_t v, input string nm);
    reset = v.rst;
    pndng = '0;
    pndng[0] = v.pn;
    D_pop = '0;
    D_pop[0] = v.dp;
    @(posedge clk);
    #1;
    chk($sformatf("%s pop", nm), 64'(pop[0]), 64'(v.epop));
    chk($sformatf("%s push", nm), 64'(push[0]), 64'(v.epush));
    chk($sformatf("%s D_push", nm), D_push[0], {4{v.edata}});
    chk($sformatf("%s bus1 pop/push", nm), 64'({pop[1], push[1]}), 64'h0);
    chk($sformatf("%s bus1 D_push", nm), D_push[1], 64'h0);
  endtask

  // Delivery mask for a packet from device src: broadcast to all others, unicast to a
  // valid other device, otherwise dropped.
  function automatic logic [3:0] deliver(input logic [15:0] p, input int src);
    int dest;
    dest = int'(p[15:8]);
    if (dest == 255) return 4'hF & ~(4'b0001 << src);
    if (dest < ND && dest != src) return 4'b0001 << dest;
    return 4'h0;
  endfunction

  initial begin
    int          last [NB];
    int          next_ok [NB];
    logic [3:0]  pend_push [NB];
    logic [3:0]  epop [NB];
    logic [3:0]  epush [NB];
    logic [15:0] exp_data [NB];
    logic [15:0] pkt;
    logic [7:0]  dst;
    bit          got;
    int          d;

    reset = 1'b1;
    pndng = '0;
    D_pop = '0;

    // Reset, then ten quiet idle cycles.
    tbl.push_back(mk(1'b1, 4'b0000, 64'h0, 4'b0000, 4'b0000, 16'h0000));
    for (int i = 0; i < 10; i++)
      tbl.push_back(mk(1'b0, 4'b0000, 64'h0, 4'b0000, 4'b0000, 16'h0000));
    // Device 1 unicast to device 2.
    tbl.push_back(mk(1'b0, 4'b0010, 64'h0000_0000_02AB_0000, 4'b0010, 4'b0000, 16'h02AB));
    tbl.push_back(mk(1'b0, 4'b0000, 64'h0000_0000_02AB_0000, 4'b0000, 4'b0100, 16'h02AB));
    tbl.push_back(mk(1'b0, 4'b0000, 64'h0, 4'b0000, 4'b0000, 16'h02AB));
    tbl.push_back(mk(1'b0, 4'b0000, 64'h0, 4'b0000, 4'b0000, 16'h02AB));
    // Device 3 broadcast.
    tbl.push_back(mk(1'b0, 4'b1000, 64'hFF5A_0000_0000_0000, 4'b1000, 4'b0000, 16'hFF5A));
    tbl.push_back(mk(1'b0, 4'b0000, 64'h0, 4'b0000, 4'b0111, 16'hFF5A));
    tbl.push_back(mk(1'b0, 4'b0000, 64'h0, 4'b0000, 4'b0000, 16'hFF5A));
    // Device 0 sends to out-of-range ID 7, device 2 sends to itself: both dropped.
    tbl.push_back(mk(1'b0, 4'b0101, 64'h0000_0233_0000_0711, 4'b0001, 4'b0000, 16'h0711));
    tbl.push_back(mk(1'b0, 4'b0100, 64'h0000_0233_0000_0711, 4'b0000, 4'b0000, 16'h0711));
    tbl.push_back(mk(1'b0, 4'b0100, 64'h0000_0233_0000_0711, 4'b0000, 4'b0000, 16'h0711));
    tbl.push_back(mk(1'b0, 4'b0100, 64'h0000_0233_0000_0000, 4'b0100, 4'b0000, 16'h0233));
    tbl.push_back(mk(1'b0, 4'b0000, 64'h0, 4'b0000, 4'b0000, 16'h0233));
    tbl.push_back(mk(1'b0, 4'b0000, 64'h0, 4'b0000, 4'b0000, 16'h0233));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Fairness: all four pending continuously, grants 0,1,2,3,0 three cycles apart.
    apply(mk(1'b1, 4'b0000, 64'h0, 4'b0000, 4'b0000, 16'h0000), "fair reset");
    for (int c = 0; c < 13; c++) begin
      reset = 1'b0;
      pndng = '0;
      pndng[0] = 4'b1111;
      D_pop = '0;
      D_pop[0] = 64'h0011_0322_0033_0144;
      @(posedge clk);
      #1;
      chk($sformatf("fair c%0d pop", c), 64'(pop[0]),
          (c % 3 == 0) ? 64'(4'b0001 << ((c / 3) % 4)) : 64'h0);
    end

    // Reset during the push state abandons the packet; the next grant restarts at device 0.
    apply(mk(1'b1, 4'b0000, 64'h0, 4'b0000, 4'b0000, 16'h0000), "rip reset0");
    apply(mk(1'b0, 4'b0010, 64'h0000_0000_02AB_0000, 4'b0010, 4'b0000, 16'h02AB), "rip grant");
    apply(mk(1'b1, 4'b0000, 64'h0, 4'b0000, 4'b0000, 16'h0000), "rip reset1");
    apply(mk(1'b0, 4'b0000, 64'h0, 4'b0000, 4'b0000, 16'h0000), "rip quiet0");
    apply(mk(1'b0, 4'b0000, 64'h0, 4'b0000, 4'b0000, 16'h0000), "rip quiet1");
    apply(mk(1'b0, 4'b0011, 64'h0000_0000_02AB_0711, 4'b0001, 4'b0000, 16'h0711), "rip regrant");

    // Randomized traffic on both buses against the grant schedule model.
    reset = 1'b1;
    pndng = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int b = 0; b < NB; b++) begin
      last[b] = ND - 1;
      next_ok[b] = 0;
      pend_push[b] = 4'h0;
      exp_data[b] = 16'h0;
    end
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int b = 0; b < NB; b++)
        for (int dv = 0; dv < ND; dv++)
          if (q[b][dv].size() < 4 && $urandom_range(0, 3) == 0) begin
            case ($urandom_range(0, 5))
              0, 1, 2, 3: dst = 8'($urandom_range(0, 3));
              4:          dst = 8'hFF;
              default:    dst = 8'($urandom_range(4, 254));
            endcase
            q[b][dv].push_back({dst, 8'($urandom)});
          end
      for (int b = 0; b < NB; b++)
        for (int dv = 0; dv < ND; dv++) begin
          pndng[b][dv] = (q[b][dv].size() > 0);
          D_pop[b][dv] = (q[b][dv].size() > 0) ? q[b][dv][0] : 16'($urandom);
        end
      for (int b = 0; b < NB; b++) begin
        epush[b] = pend_push[b];
        pend_push[b] = 4'h0;
        epop[b] = 4'h0;
        if (cyc >= next_ok[b]) begin
          got = 1'b0;
          for (int i = 1; i <= ND; i++) begin
            d = (last[b] + i) % ND;
            if (!got && q[b][d].size() > 0) begin
              got = 1'b1;
              pkt = q[b][d].pop_front();
              epop[b][d] = 1'b1;
              exp_data[b] = pkt;
              pend_push[b] = deliver(pkt, d);
              next_ok[b] = cyc + 3;
              last[b] = d;
            end
          end
        end
      end
      @(posedge clk);
      #1;
      for (int b = 0; b < NB; b++) begin
        chk($sformatf("rnd c%0d b%0d pop", cyc, b), 64'(pop[b]), 64'(epop[b]));
        chk($sformatf("rnd c%0d b%0d push", cyc, b), 64'(push[b]), 64'(epush[b]));
        chk($sformatf("rnd c%0d b%0d D_push", cyc, b), D_push[b], {4{exp_data[b]}});
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bs_gnrtr_n_rbtr.md
BS_GNRTR_N_RBTR -- requirements
Module: bs_gnrtr_n_rbtr

Interface
REQ-001 Parameter bits, default 1: number of independent buses; each bus is an identical, independent copy of the logic below.
REQ-002 Parameter drvrs, default 4: devices attached per bus, range 2..254.
REQ-003 Parameter pckg_sz, default 16: packet width in bits, minimum 9.
REQ-004 Parameter broadcast, default 8'hFF: destination ID that addresses every device except the sender.
REQ-005 Clocking: one clock; reset is synchronous and active-high.
REQ-006 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 Port reset, input, 1 bit: synchronous active-high reset.
REQ-008 Port pndng, input, packed [bits-1:0][drvrs-1:0]: device d has at least one packet queued.
REQ-009 Port D_pop, input, packed [bits-1:0][drvrs-1:0][pckg_sz-1:0]: head packet of device d's queue, valid whenever pndng is 1.
REQ-010 Port pop, output, packed [bits-1:0][drvrs-1:0]: one-cycle pulse that removes the head of device d's queue.
REQ-011 Port push, output, packed [bits-1:0][drvrs-1:0]: one-cycle pulse meaning D_push[b][d] holds a packet delivered to device d.
REQ-012 Port D_push, output, packed [bits-1:0][drvrs-1:0][pckg_sz-1:0]: every device on a bus sees that bus's data register.
REQ-013 Packet format: bits [pckg_sz-1:pckg_sz-8] are the destination ID; the remaining low bits are payload and are passed through unmodified.

Function
REQ-014 Each bus has a three-state FSM: IDLE, PUSH, WAIT.
REQ-015 In IDLE with no pndng bit set, the bus stays in IDLE and keeps all pop and push outputs at 0.
REQ-016 In IDLE with any pndng bit set, the bus grants one device by round-robin.
- Search starts at (last granted index + 1) mod drvrs and picks the first device with pndng set.
REQ-017 On a grant in IDLE, at the same rising edge:
- pop[sel] <= 1 for exactly one cycle;
- bus data register <= D_pop[sel];
- source register <= sel;
- state <= PUSH.
REQ-018 In PUSH, pop <= 0, then decode the destination ID dest:
- dest == broadcast: push <= 1 for every device except the source;
- dest < drvrs and dest != source: push[dest] <= 1;
- dest == source, or dest >= drvrs and not broadcast: packet dropped, no push.
- In all cases state <= WAIT.
REQ-019 In WAIT, all push outputs <= 0 and state <= IDLE; this gives the popped device one cycle to update pndng.
REQ-020 Each push pulse lasts exactly one cycle; D_push stays stable from the PUSH edge until the next grant.
REQ-021 Latency: a pndng bit sampled at edge N gives pop high during cycle N..N+1 and push high during cycle N+1..N+2.
REQ-022 Throughput: at most one packet per bus every 3 cycles.
REQ-023 Fairness: with all devices pending continuously, grants are issued in strictly rotating order 0, 1, ..., drvrs-1, 0, ...
REQ-024 pndng changes while in PUSH or WAIT are ignored until the next IDLE cycle.
REQ-025 Separate buses never interact.

Reset
REQ-026 While reset is 1 at a rising edge, the following outputs clear:
- pop = 0, push = 0, D_push = 0;
- state = IDLE;
- last-granted pointer = drvrs-1, so the first grant goes to device 0.
REQ-027 Reset asserted during PUSH or WAIT abandons the in-flight packet with no push issued; a pop already issued is not undone.

Verification
REQ-028 The bench shall cover: reset, then idle with pndng = 0 for 10 cycles -> pop and push stay 0 and D_push = 0.
REQ-029 The bench shall cover (drvrs = 4, pckg_sz = 16): device 1 pending with D_pop = 16'h02AB -> pop[1] pulses one cycle later, push[2] pulses one cycle after that, D_push = 16'h02AB, no other push bit set.
REQ-030 The bench shall cover: device 3 sends 16'hFF5A -> push[0], push[1] and push[2] pulse together, push[3] stays 0.
REQ-031 The bench shall cover: all four devices pending continuously -> pop order 0, 1, 2, 3, 0, with grants 3 cycles apart.
REQ-032 The bench shall cover: device 0 sends 16'h0711 (dest 7 >= drvrs) and device 2 sends 16'h0233 (dest == source) -> each popped once, no push.
REQ-033 The bench shall cover: reset asserted in the PUSH state -> no push pulse follows, outputs return to 0, and the next grant goes to device 0.
